// File: rtl/study_judge.sv
// Study-mode judge: fetches expected notes, debounces key/pitch presses and scores each note.
// Optional feature: define STUDY_TIMEOUT_EN to turn an unanswered note into a miss after TIMEOUT_MS.
module study_judge #(
   parameter int CLK_HZ      = 100_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int TIMEOUT_MS  = 3000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [6:0] key,
   input  logic [1:0] pitch,
   output logic       note_req,
   input  logic       exp_valid,
   input  logic [4:0] exp_note,
   input  logic       exp_end,
   output logic [7:0] led,
   output logic [7:0] score,
   output logic [7:0] miss,
   output logic       result_valid,
   output logic       result_hit,
   output logic       done
);

   localparam int DB_CYC  = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int TO_CYC  = CLK_HZ / 1000 * TIMEOUT_MS;
   localparam int CNT_MAX = (DB_CYC > TO_CYC) ? DB_CYC : TO_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);
`ifdef STUDY_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_KEY,
      S_DEBOUNCE,
      S_JUDGE,
      S_WAIT_REL,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_CLR,
      CNT_INC
   } cnt_op_t;

   state_t           state, state_nxt;
   cnt_op_t          cnt_op;
   logic [CNT_W-1:0] cnt;
   logic             req_nxt;
   logic             latch_exp, latch_key;
   logic             to_fire, to_flag;

   logic [6:0] key_p0, key_p1;
   logic [1:0] pitch_p0, pitch_p1;
   logic [2:0] exp_idx;
   logic [1:0] exp_pitch;
   logic [6:0] key_lat;
   logic [1:0] pitch_lat;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [6:0] idx_onehot(input logic [2:0] idx);
      return (idx == 3'd0) ? 7'd0 : 7'(7'd1 << (idx - 3'd1));
   endfunction

   function automatic logic is_hit(input logic [6:0] k, input logic [1:0] p,
                                   input logic [2:0] idx, input logic [1:0] ep);
      return (idx != 3'd0) && (k == idx_onehot(idx)) && (p == ep);
   endfunction

   // stage p0/p1: two-flop synchroniser for the raw switches
   always_ff @(posedge clk) begin
      key_p0   <= key;
      pitch_p0 <= pitch;
      key_p1   <= key_p0;
      pitch_p1 <= pitch_p0;
   end

   always_ff @(posedge clk) begin
      if (latch_exp) begin
         exp_idx   <= exp_note[2:0];
         exp_pitch <= exp_note[4:3];
      end
      if (latch_key) begin
         key_lat   <= key_p1;
         pitch_lat <= pitch_p1;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_op    = CNT_HOLD;
      req_nxt   = 1'b0;
      latch_exp = 1'b0;
      latch_key = 1'b0;
      to_fire   = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_op = CNT_CLR;
            if (en) begin
               state_nxt = S_FETCH;
               req_nxt   = 1'b1;
            end
         end
         S_FETCH: begin
            if (exp_valid) begin
               if (exp_end) begin
                  state_nxt = S_DONE;
               end else if (exp_note[2:0] == 3'd0) begin
                  req_nxt = 1'b1;
               end else begin
                  latch_exp = 1'b1;
                  cnt_op    = CNT_CLR;
                  state_nxt = S_WAIT_KEY;
               end
            end
         end
         S_WAIT_KEY: begin
            // a press seen in the same cycle as the timeout takes priority
            if (key_p1 != 7'd0) begin
               latch_key = 1'b1;
               cnt_op    = CNT_CLR;
               state_nxt = S_DEBOUNCE;
            end else if (TO_EN && (cnt == TO_LAST)) begin
               to_fire   = 1'b1;
               state_nxt = S_JUDGE;
            end else if (TO_EN) begin
               cnt_op = CNT_INC;
            end
         end
         S_DEBOUNCE: begin
            if (key_p1 == 7'd0) begin
               cnt_op    = CNT_CLR;
               state_nxt = S_WAIT_KEY;
            end else if ({key_p1, pitch_p1} != {key_lat, pitch_lat}) begin
               latch_key = 1'b1;
               cnt_op    = CNT_CLR;
            end else if (cnt == DB_LAST) begin
               state_nxt = S_JUDGE;
            end else begin
               cnt_op = CNT_INC;
            end
         end
         S_JUDGE: begin
            cnt_op = CNT_CLR;
            if (to_flag) begin
               state_nxt = S_FETCH;
               req_nxt   = 1'b1;
            end else begin
               state_nxt = S_WAIT_REL;
            end
         end
         S_WAIT_REL: begin
            if (key_p1 != 7'd0) begin
               cnt_op = CNT_CLR;
            end else if (cnt == DB_LAST) begin
               state_nxt = S_FETCH;
               req_nxt   = 1'b1;
            end else begin
               cnt_op = CNT_INC;
            end
         end
         S_DONE: begin
            state_nxt = S_DONE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      // leaving study mode abandons the session from any state
      if (!en) begin
         state_nxt = S_IDLE;
         req_nxt   = 1'b0;
         cnt_op    = CNT_CLR;
         to_fire   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         note_req <= 1'b0;
         to_flag  <= 1'b0;
      end else begin
         state    <= state_nxt;
         note_req <= req_nxt;
         to_flag  <= to_fire;
         case (cnt_op)
            CNT_CLR: cnt <= '0;
            CNT_INC: cnt <= cnt + CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_comb begin
      led          = 8'h00;
      result_valid = 1'b0;
      result_hit   = 1'b0;
      done         = 1'b0;
      case (state)
         S_WAIT_KEY: led = {1'b0, idx_onehot(exp_idx)};
         S_JUDGE: begin
            result_valid = 1'b1;
            result_hit   = !to_flag && is_hit(key_lat, pitch_lat, exp_idx, exp_pitch);
         end
         S_DONE: begin
            led  = 8'h80;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n || !en) begin
         score <= 8'h00;
         miss  <= 8'h00;
      end else if (state == S_JUDGE) begin
         if (result_hit) score <= sat_inc(score);
         else            miss  <= sat_inc(miss);
      end
   end

endmodule

// File: doc/study_judge.md
# study_judge

Scoring stage for study mode, sitting between the song note source and the LED/seven-segment output selection. It requests expected notes one at a time, shows the expected key on the LEDs, and debounces the player's key and pitch switches. Each press is judged against the expected note, and the block keeps saturating hit and miss counts for the display path. A song-end handshake ends the session.

## Interface
Parameters:
- CLK_HZ, 100_000_000, clock frequency.
- DEBOUNCE_MS, 20, stable time required on key press and release.
- TIMEOUT_MS, 3000, time allowed per note before it counts as a miss.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  synchronous, active-high reset. The legacy name is kept for top-level consistency.
- en  in  1  study mode active (mode == 3'b111). Level-sensitive.
- key  in  7  raw key switches; bit0 = do … bit6 = si.
- pitch  in  2  raw pitch switches.
- note_req  out  1  one-cycle pulse requesting the next expected note.
- exp_valid  in  1  expected note present; sampled only while waiting for a note.
- exp_note  in  5  {pitch[1:0], idx[2:0]}; idx 1..7 = do..si, idx 0 = rest.
- exp_end  in  1  qualified by exp_valid; no more notes.
- led  out  8  one-hot idx-1 of expected note while waiting for a key; led[7] = done; 0 otherwise.
- score  out  8  hit count, saturating at 255.
- miss  out  8  miss count, saturating at 255.
- result_valid  out  1  one-cycle pulse for each judged note.
- result_hit  out  1  verdict, valid with result_valid.
- done  out  1  session finished.

## Operation
- Derived constants:
  - DB_CYC = CLK_HZ/1000*DEBOUNCE_MS.
  - TO_CYC = CLK_HZ/1000*TIMEOUT_MS.
  - One shared cycle counter sized for the larger of the two.
- State machine, with transitions:
  - IDLE:
    - Counters cleared, all outputs 0.
    - en=1 → FETCH.
  - FETCH:
    - Pulse note_req on entry only.
    - Wait for exp_valid.
    - exp_valid & exp_end → DONE.
    - exp_valid & idx==0 (rest) → FETCH again; new note_req; no verdict.
    - Otherwise latch exp_note → WAIT_KEY.
  - WAIT_KEY:
    - led = one-hot of latched idx.
    - Counter runs.
    - key != 0 → latch key and pitch, clear counter → DEBOUNCE.
    - Counter reaches TO_CYC-1 with key == 0 → miss, then FETCH.
  - DEBOUNCE:
    - {key,pitch} differs from latch but key != 0 → relatch, restart counter.
    - key == 0 → WAIT_KEY; the timeout counter restarts from 0.
    - Stable for DB_CYC cycles → JUDGE.
  - JUDGE (1 cycle):
    - Hit iff latched key is exactly one-hot, equals 1<<(idx-1), and latched pitch == expected pitch.
    - Multiple keys or wrong key/pitch = miss.
    - Pulse result_valid; update score or miss → WAIT_RELEASE.
  - WAIT_RELEASE:
    - key must read 0 for DB_CYC consecutive cycles; any nonzero restarts the count.
    - Then → FETCH.
  - DONE:
    - done=1, led[7]=1; score and miss held.
    - en=0 → IDLE.
- en=0 in any state → IDLE next cycle. Counters clear and no verdict is issued.
- Saturation: an increment at 255 leaves the value at 255.
- Key and pitch are double-flop synchronised before use; all judgement uses the synchronised values.

## Timing
- Reset value of every output: 0. State = IDLE.
- note_req: high exactly one cycle, the first cycle of FETCH.
- exp_valid may arrive in the same cycle as note_req or later. The source must hold exp_note until consumed.
- Key latency: input change reaches the FSM 2 cycles later (synchroniser).
- Press to result_valid: 2 + DB_CYC + 1 cycles.
- Counter update: score/miss update in the same cycle result_valid is high; visible the next cycle.
- Timeout miss: result_valid pulses TO_CYC cycles after WAIT_KEY entry, with result_hit=0.
- If a stable press completes in the same cycle the timeout would fire, the press wins; timeout does not apply in DEBOUNCE.
- en=0 during a JUDGE cycle: the verdict of that cycle is still issued, and the state then goes to IDLE.

## Configuration
- STUDY_TIMEOUT_EN:
  - Defined: per-note timeout active as described.
  - Undefined: WAIT_KEY waits indefinitely; a miss comes only from wrong presses; TIMEOUT_MS ignored.

## Test plan
Bench settings: CLK_HZ=1000, DEBOUNCE_MS=3, TIMEOUT_MS=20 (DB_CYC=3, TO_CYC=20); source answers note_req in 1 cycle.
- Correct press: rst, en=1, note {01,3'd3}; key=7'b0000100, pitch=01 held 10 cycles, then released → led=8'b00000100, result_hit=1, score=1, next note_req after release debounce.
- Wrong press: expected mi, key=7'b0000110 held → result_hit=0, miss=1, score unchanged.
- Bounce: key toggles 0/mi every 2 cycles for 10 cycles, then stays → exactly one result_valid, score=1.
- Timeout with STUDY_TIMEOUT_EN: no key → result_valid 20 cycles after WAIT_KEY entry, miss=1. Without the macro: no result after 100 cycles.
- Rest and end: notes rest, do, then exp_end → no verdict for the rest, one verdict for do, done=1, led[7]=1. Dropping en → all outputs 0 next cycle.
- Saturation: 260 correct notes → score=255; mid-session rst_n → all outputs 0, state IDLE.
